// File: rtl/gray_counter_if.sv
// gray_counter_if: control, load data and count outputs of the Gray counter
interface gray_counter_if #(parameter int N = 6);
    logic         en;
    logic         up;
    logic         load;
    logic [N-1:0] bin_data_in;
    logic [N-1:0] bin_data_out;
    logic [N-1:0] gray_data_out;
    logic         wrap;
    modport master (output en, up, load, bin_data_in, input bin_data_out, gray_data_out, wrap);
    modport slave  (input en, up, load, bin_data_in, output bin_data_out, gray_data_out, wrap);
endinterface

// File: rtl/gray_counter.sv
// gray_counter: loadable up/down binary counter with registered Gray code and roll-over pulse
module gray_counter #(parameter int N = 6) (
    input  logic         clk,
    input  logic         rst_n,
    gray_counter_if.slave bus
);
    logic [N-1:0] b, g, nb;
    logic         w, nw;
    // Gray is encoded from the next binary value so both registers move on the same edge
    always_comb begin
        nb = bus.load ? bus.bin_data_in : !bus.en ? b : bus.up ? b + N'(1) : b - N'(1);
        nw = !bus.load && bus.en && (bus.up ? &b : ~|b);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b <= '0;
            g <= '0;
            w <= 1'b0;
        end else begin
            b <= nb;
            g <= nb ^ (nb >> 1);
            w <= nw;
        end
    end
    assign bus.bin_data_out  = b;
    assign bus.gray_data_out = g;
    assign bus.wrap          = w;
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed checks of the N=6 Gray counter plus a random invariant run
module tb_gray_counter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int passed = 0;
    gray_counter_if #(.N(6)) bus ();
    gray_counter #(.N(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int b, input int g, input int w);
        check({tag, "_bin"}, 32'(bus.bin_data_out), 32'(b));
        check({tag, "_gray"}, 32'(bus.gray_data_out), 32'(g));
        check({tag, "_wrap"}, 32'(bus.wrap), 32'(w));
    endtask

    initial begin
        int gseq[8];
        logic [5:0] prev, mb;
        logic ew;
        gseq = '{0, 1, 3, 2, 6, 7, 5, 4};
        bus.en = 1'b1;
        bus.up = 1'b1;
        bus.load = 1'b1;
        bus.bin_data_in = 6'd33;
        #3;
        expect_out("reset_initial", 0, 0, 0);
        step();
        expect_out("reset_held", 0, 0, 0);
        rst_n = 1'b1;
        bus.load = 1'b0;
        prev = 6'd0;
        for (int i = 1; i <= 64; i++) begin
            step();
            check("sweep_bin", 32'(bus.bin_data_out), 32'(i % 64));
            check("sweep_onebit", 32'($countones(bus.gray_data_out ^ prev)), 32'd1);
            check("sweep_wrap", 32'(bus.wrap), (i == 64) ? 32'd1 : 32'd0);
            if (i < 8) check("sweep_gseq", 32'(bus.gray_data_out), 32'(gseq[i]));
            prev = bus.gray_data_out;
        end
        step();
        expect_out("sweep_after_wrap", 1, 1, 0);
        bus.load = 1'b1;
        bus.bin_data_in = 6'd0;
        step();
        expect_out("load0", 0, 0, 0);
        bus.load = 1'b0;
        bus.up = 1'b0;
        step();
        expect_out("down_wrap", 63, 32, 1);
        step();
        expect_out("down_next", 62, 33, 0);
        bus.load = 1'b1;
        bus.en = 1'b0;
        bus.bin_data_in = 6'd63;
        step();
        expect_out("load63", 63, 32, 0);
        bus.load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_out("hold63", 63, 32, 0);
        end
        bus.en = 1'b1;
        bus.up = 1'b1;
        step();
        expect_out("up_wrap", 0, 0, 1);
        bus.up = 1'b0;
        step();
        expect_out("dir_change", 63, 32, 1);
        bus.load = 1'b1;
        bus.bin_data_in = 6'd45;
        step();
        expect_out("load45", 45, 59, 0);
        bus.up = 1'b1;
        bus.bin_data_in = 6'd10;
        step();
        expect_out("load_en", 10, 15, 0);
        bus.bin_data_in = 6'd17;
        step();
        expect_out("load17", 17, 25, 0);
        bus.load = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        expect_out("async_reset", 0, 0, 0);
        bus.load = 1'b1;
        bus.bin_data_in = 6'd9;
        step();
        expect_out("reset_over_load", 0, 0, 0);
        rst_n = 1'b1;
        bus.bin_data_in = 6'd5;
        step();
        expect_out("first_after_reset", 5, 7, 0);
        mb = 6'd5;
        for (int i = 0; i < 10000; i++) begin
            bus.load = ($urandom_range(15) == 0);
            bus.en = 1'($urandom_range(1));
            bus.up = 1'($urandom_range(1));
            bus.bin_data_in = 6'($urandom);
            ew = !bus.load && bus.en && (bus.up ? (mb == 6'd63) : (mb == 6'd0));
            mb = bus.load ? bus.bin_data_in : !bus.en ? mb : bus.up ? mb + 6'd1 : mb - 6'd1;
            step();
            check("rand_gray", 32'(bus.gray_data_out), 32'(bus.bin_data_out ^ (bus.bin_data_out >> 1)));
            check("rand_bin", 32'(bus.bin_data_out), 32'(mb));
            check("rand_wrap", 32'(bus.wrap), 32'(ew));
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
